fft_frame_loader: RTL and testbench

//   Parametrised frame sequencer feeding the fft core's load port (insert_data/addr/data_in).

---
 rtl/fft_frame_loader.sv | 133 +++++++++++++
 tb/tb_fft_frame_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_loader.sv
// Frame sequencer for the fft load port: pulls N samples from a test ROM or a
// valid-qualified stream, then waits for the fft to finish before counting the frame.
`timescale 1ns/1ps

module fft_frame_loader #(
    parameter int N           = 16,
    parameter int W           = 16,
    parameter int START_DELAY = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode_cont,
    input  logic                 src_sel,
    output logic [$clog2(N)-1:0] rom_addr,
    input  logic [W-1:0]         rom_data,
    input  logic [W-1:0]         stream_data,
    input  logic                 stream_valid,
    output logic                 stream_ready,
    output logic                 insert_data,
    output logic [$clog2(N)-1:0] addr,
    output logic [W-1:0]         data_out,
    input  logic                 fft_finish,
    output logic                 frame_done,
    output logic [15:0]          frame_count,
    output logic                 busy,
    output logic                 overrun
);

    localparam int AW = $clog2(N);
    // Wide enough for START_DELAY itself, and at least one bit when START_DELAY is 0.
    localparam int CW = $clog2(START_DELAY + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_LOAD,
        S_PROC
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_src;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_idx;
    logic            r_insert;
    logic [AW-1:0]   r_addr;
    logic [W-1:0]    r_data;
    logic            r_frame_done;
    logic [15:0]     r_frame_count;
    logic            r_overrun;

    logic            w_beat;
    logic            w_last;
    logic            w_finish;
    logic            w_launch;
    logic            w_drop;
    logic            w_ready;
    logic [W-1:0]    w_sample;

    assign w_ready  = (r_state == S_LOAD) && r_src;
    assign w_beat   = (r_state == S_LOAD) && (r_src ? stream_valid : 1'b1);
    assign w_last   = w_beat && (r_idx == AW'(N - 1));
    assign w_finish = (r_state == S_PROC) && fft_finish;
    assign w_launch = ((r_state == S_IDLE) && start) || (w_finish && mode_cont);
    assign w_sample = r_src ? stream_data : rom_data;
    // A stream beat is lost whenever it is offered and not taken, except while a ROM frame runs.
    assign w_drop   = stream_valid && !w_ready && ((r_state == S_IDLE) || r_src);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (start)             w_next_state = S_WAIT;
            S_WAIT: if (r_cnt == '0)       w_next_state = S_LOAD;
            S_LOAD: if (w_last)            w_next_state = S_PROC;
            S_PROC: if (fft_finish)        w_next_state = mode_cont ? S_WAIT : S_IDLE;
            default:                       w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_src         <= 1'b0;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_insert      <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_overrun     <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_launch) begin
                r_src <= src_sel;
                r_cnt <= CW'(START_DELAY);
            end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CW'(1);
            end

            if (w_beat) begin
                r_idx  <= w_last ? '0 : r_idx + AW'(1);
                r_addr <= r_idx;
                r_data <= w_sample;
            end
            r_insert <= w_beat;

            r_frame_done <= w_finish;
            if (w_finish) begin
                r_frame_count <= r_frame_count + 16'd1;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign rom_addr     = r_idx;
    assign stream_ready = w_ready;
    assign insert_data  = r_insert;
    assign addr         = r_addr;
    assign data_out     = r_data;
    assign frame_done   = r_frame_done;
    assign frame_count  = r_frame_count;
    assign busy         = (r_state != S_IDLE);
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Self-checking bench for fft_frame_loader: table of frame scenarios plus hand-written
// sequences for continuous mode, overrun and mid-frame reset.
`timescale 1ns/1ps

module tb_fft_frame_loader;

    localparam int N  = 16;
    localparam int W  = 16;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode_cont = 1'b0;
    logic          src_sel = 1'b0;
    logic [3:0]    rom_addr;
    logic [W-1:0]  rom_data;
    logic [W-1:0]  stream_data = '0;
    logic          stream_valid = 1'b0;
    logic          stream_ready;
    logic          insert_data;
    logic [3:0]    addr;
    logic [W-1:0]  data_out;
    logic          fft_finish = 1'b0;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic          busy;
    logic          overrun;

    fft_frame_loader #(.N(N), .W(W), .START_DELAY(SD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode_cont(mode_cont), .src_sel(src_sel),
        .rom_addr(rom_addr), .rom_data(rom_data), .stream_data(stream_data),
        .stream_valid(stream_valid), .stream_ready(stream_ready), .insert_data(insert_data),
        .addr(addr), .data_out(data_out), .fft_finish(fft_finish), .frame_done(frame_done),
        .frame_count(frame_count), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rom_model(input logic [3:0] a);
        return {4'hC, a, ~a, a};
    endfunction

    assign rom_data = rom_model(rom_addr);

    typedef struct packed {
        logic [3:0]   addr;
        logic [W-1:0] data;
    } beat_t;

    typedef struct {
        logic src;
        int   period;
        int   exp_span;
    } vec_t;

    beat_t sb[$];
    beat_t exp_beat;
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    n_ins = 0;
    int    first_ins = 0;
    int    last_ins = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && insert_data) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_insert: got addr 0x%0h expected no insert", addr);
            end else begin
                exp_beat = sb.pop_front();
                check("insert_addr", 32'(addr), 32'(exp_beat.addr));
                check("insert_data", 32'(data_out), 32'(exp_beat.data));
            end
            if (n_ins == 0) first_ins = cyc;
            last_ins = cyc;
            n_ins++;
        end
    end

    task automatic launch(input logic src, output int t0);
        @(posedge clk); #1;
        start   = 1'b1;
        src_sel = src;
        @(posedge clk); #1;
        t0    = cyc;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic load_frame(input logic src, input int period, input int exp_span, input int t0);
        int beats;
        int c;
        n_ins = 0;
        if (!src) begin
            for (int k = 0; k < N; k++) sb.push_back({4'(k), rom_model(4'(k))});
        end
        while (cyc < t0 + SD + 1) begin
            @(posedge clk); #1;
        end
        if (src) begin
            beats = 0;
            c = 0;
            while (beats < N) begin
                stream_valid = ((c % period) == 0);
                stream_data  = W'($urandom);
                if (stream_valid) begin
                    sb.push_back({4'(beats), stream_data});
                    beats++;
                end
                @(posedge clk); #1;
                c++;
            end
            stream_valid = 1'b0;
        end
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("insert_count", 32'(n_ins), 32'(N));
        check("first_insert_latency", 32'(first_ins - t0), 32'(SD + 2));
        check("insert_span", 32'(last_ins - first_ins + 1), 32'(exp_span));
        @(negedge clk);
        check("process_insert_low", 32'(insert_data), 32'd0);
        check("process_busy", 32'(busy), 32'd1);
    endtask

    task automatic finish_frame(input logic cont, input int exp_count, output int tf);
        @(posedge clk); #1;
        mode_cont  = cont;
        fft_finish = 1'b1;
        @(posedge clk); #1;
        tf         = cyc;
        fft_finish = 1'b0;
        mode_cont  = 1'b0;
        @(negedge clk);
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        check("frame_count", 32'(frame_count), 32'(exp_count));
        check("busy_after_finish", 32'(busy), 32'(cont));
        @(negedge clk);
        check("frame_done_single", 32'(frame_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        int t0;
        int tf;

        vecs[0] = '{src: 1'b0, period: 1, exp_span: 16};
        vecs[1] = '{src: 1'b1, period: 1, exp_span: 16};
        vecs[2] = '{src: 1'b1, period: 2, exp_span: 31};
        vecs[3] = '{src: 1'b1, period: 3, exp_span: 46};

        repeat (2) @(negedge clk);
        check("rst_insert", 32'(insert_data), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(frame_count), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_ready", 32'(stream_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            launch(vecs[i].src, t0);
            load_frame(vecs[i].src, vecs[i].period, vecs[i].exp_span, t0);
            finish_frame(1'b0, i + 1, tf);
        end
        check("no_overrun_yet", 32'(overrun), 32'd0);

        // fft_finish while idle must be ignored.
        @(posedge clk); #1;
        fft_finish = 1'b1;
        @(posedge clk); #1;
        fft_finish = 1'b0;
        @(negedge clk);
        check("idle_finish_done", 32'(frame_done), 32'd0);
        check("idle_finish_count", 32'(frame_count), 32'd4);
        check("idle_finish_busy", 32'(busy), 32'd0);

        // Continuous mode: three frames with a single start.
        launch(1'b0, t0);
        load_frame(1'b0, 1, 16, t0);
        finish_frame(1'b1, 5, tf);
        load_frame(1'b0, 1, 16, tf);
        finish_frame(1'b1, 6, tf);
        load_frame(1'b0, 1, 16, tf);
        finish_frame(1'b0, 7, tf);

        // Stream beat offered during PROCESS sets the sticky overrun flag.
        launch(1'b1, t0);
        load_frame(1'b1, 1, 16, t0);
        check("ready_low_in_process", 32'(stream_ready), 32'd0);
        @(posedge clk); #1;
        stream_valid = 1'b1;
        @(posedge clk); #1;
        stream_valid = 1'b0;
        @(negedge clk);
        check("overrun_set", 32'(overrun), 32'd1);
        finish_frame(1'b0, 8, tf);
        launch(1'b0, t0);
        load_frame(1'b0, 1, 16, t0);
        finish_frame(1'b0, 9, tf);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of a ROM load, then a clean frame from address 0.
        launch(1'b0, t0);
        for (int k = 0; k < N; k++) sb.push_back({4'(k), rom_model(4'(k))});
        while (cyc < t0 + SD + 2 + 7) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("midload_addr", 32'(addr), 32'd7);
        check("midload_insert", 32'(insert_data), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("async_rst_insert", 32'(insert_data), 32'd0);
        check("async_rst_addr", 32'(addr), 32'd0);
        check("async_rst_rom_addr", 32'(rom_addr), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_count", 32'(frame_count), 32'd0);
        check("async_rst_overrun", 32'(overrun), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        launch(1'b0, t0);
        load_frame(1'b0, 1, 16, t0);
        finish_frame(1'b0, 1, tf);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
